run_checker: RTL and testbench
==============================

Name: run_checker

Overview:
- Synthesizable run controller and result checker for the `singlecycle` core: the hardware counterpart of the bench that drives the core and judges its results.
- Issues the reset/startpc sequence to the core, then watches `currentpc` until each program's end PC is reached.
- At that point it compares `MemtoRegOut` against that program's expected value, enforcing a global watchdog throughout.
- Sits beside the core on FPGA builds and drives pass/fail LEDs and status registers.

Parameters:
- NUM_PROGS, 2, number of back-to-back programs checked per run (1..8)
- WDOG_LIMIT, 255, cycle budget for the whole run, across all programs
- RST_CYCLES, 1, cycles `cpu_resetl` is held low (1..15)

Ports:
- CLK  in  1  core clock
- reset  in  1  async active-high reset
- start  in  1  one-cycle pulse to begin a run; honoured only in IDLE or DONE
- start_pc  in  64  value driven on `cpu_startpc` during the core reset
- end_pc  in  64*NUM_PROGS  per-program end PC; slot i = bits [64i+63:64i]
- expect_val  in  64*NUM_PROGS  per-program expected `MemtoRegOut`, same packing
- currentpc  in  64  core current PC
- MemtoRegOut  in  64  core writeback value
- cpu_resetl  out  1  active-low reset to the core
- cpu_startpc  out  64  start PC to the core
- busy  out  1  run in progress
- done  out  1  run finished; held until next start
- pass_mask  out  NUM_PROGS  bit i set = program i passed
- pass_count  out  8  number of programs passed
- all_passed  out  1  done && pass_count==NUM_PROGS
- wdog_expired  out  1  run aborted by watchdog
- fail_value  out  64  `MemtoRegOut` captured at the first failing check

Behaviour:
- Reset is asynchronous. Reset values:
  - `cpu_resetl`=1
  - `cpu_startpc`=0
  - `busy`=0, `done`=0
  - `pass_mask`=0, `pass_count`=0
  - `wdog_expired`=0
  - `fail_value`=0
  - state=IDLE, idx=0, wdog=0, rst_cnt=0
- States: IDLE, RST, RUN, DONE.
- IDLE / DONE:
  - When `start`=1, on that edge: clear `pass_mask`, `pass_count`, `wdog_expired`, `fail_value`, `done`, idx and wdog.
  - Latch `start_pc` into `cpu_startpc`, drive `cpu_resetl`=0, set `busy`=1, load rst_cnt=RST_CYCLES-1, go to RST.
- RST:
  - `cpu_resetl` stays 0 for exactly RST_CYCLES cycles, then rises on the transition to RUN.
  - `cpu_startpc` is held stable through RST and RUN.
- RUN, evaluated on each edge:
  - Reach condition: `currentpc` >= end_pc[idx], unsigned 64-bit.
  - If reached:
    - Compare `MemtoRegOut` with expect_val[idx].
    - On match: set pass_mask[idx] and increment `pass_count`.
    - On mismatch: capture `fail_value` if no failure has been captured yet.
    - If idx==NUM_PROGS-1, go to DONE; otherwise idx++ and stay in RUN (the core keeps executing; no re-reset).
  - If not reached: wdog++. When wdog reaches WDOG_LIMIT, set `wdog_expired`=1 and go to DONE; unchecked programs remain 0 in `pass_mask`.
  - Reach and watchdog on the same edge: reach wins, and the watchdog does not fire that cycle.
  - One check per cycle at most. If `currentpc` already satisfies the next slot's end_pc, that slot is checked on the following edge.
- DONE:
  - `busy`=0, `done`=1, `cpu_resetl`=1; all results held.
  - `all_passed` is combinational from `done` and `pass_count`.
- `start` while `busy`=1 is ignored.
- Async `reset` mid-run returns every output to its reset value immediately. The core is released from reset (`cpu_resetl`=1).
- wdog is 16 bits and saturates; it does not wrap. The watchdog is global: it is not cleared between programs.

Decomposition:
- Shared package `run_checker_pkg` holds:
  - state enum
  - PC_W=64, DATA_W=64
  - helper function extracting slot i from a packed 64*N vector
- Sub-module `run_watchdog` is natural: a saturating counter with clear, enable and `expired` compare. The rest stays in the top.
- The bench uses a behavioural core model: PC := startpc on `cpu_resetl`=0, else PC += 4 each cycle; `MemtoRegOut` is driven by the bench.

Test Plan:
1. Nominal run, NUM_PROGS=2:
   - Stimulus: start_pc=0, end_pc={0x54,0x30}, expect={0x123456789abcdef0,0xF}, model drives the matching values at PC 0x30 and 0x54.
   - Required: `pass_mask`=2'b11, `pass_count`=2, `all_passed`=1, `wdog_expired`=0, `done`=1.
2. Mismatch on program 0:
   - Stimulus: model drives 0xE at PC 0x30, program 1 correct.
   - Required: `pass_mask`=2'b10, `pass_count`=1, `fail_value`=0xE, `all_passed`=0.
3. Watchdog:
   - Stimulus: model PC stuck at 0x10, WDOG_LIMIT=255.
   - Required: `wdog_expired`=1 exactly 255 RUN cycles after entering RUN, `pass_mask`=0, `done`=1.
4. Reset sequencing, RST_CYCLES=3, start_pc=0x100:
   - Required: `cpu_resetl` low for exactly 3 cycles; `cpu_startpc`=0x100 throughout.
   - Required: `start` pulses during RUN leave state unchanged.
5. Reset mid-run:
   - Stimulus: assert `reset` asynchronously during RUN with idx=1.
   - Required: all outputs at reset values before the next edge, state=IDLE. A new `start` then completes scenario 1 correctly.
6. Simultaneous events:
   - Stimulus: reach occurs on the same cycle wdog would hit the limit; separately end_pc={0x30,0x30}.
   - Required: first case passes with no expiry. Second case checks slot 0 then slot 1 on consecutive edges, and both pass when values match.

Source files
------------

// File: rtl/run_checker_pkg.sv
// ---------------------------------------------------------------------------
// run_checker_pkg
//   Shared types and helpers for the run controller / result checker.
//   - state_e   : controller states
//   - PC_W      : width of core program counter
//   - DATA_W    : width of core writeback value
//   - get_slot  : extracts 64-bit slot i from a packed per-program vector
// ---------------------------------------------------------------------------
package run_checker_pkg;

  localparam int unsigned PC_W      = 64;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned SLOT_W    = 64;
  localparam int unsigned MAX_PROGS = 8;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned VEC_W     = SLOT_W * MAX_PROGS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RST  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Callers zero-extend their NUM_PROGS-wide vector to VEC_W, so one helper
  // serves every NUM_PROGS setting.
  function automatic logic [SLOT_W-1:0] get_slot(input logic [VEC_W-1:0] vec,
                                                 input logic [IDX_W-1:0] i);
    return vec[i*SLOT_W +: SLOT_W];
  endfunction

endpackage

// File: rtl/run_watchdog.sv
// ---------------------------------------------------------------------------
// run_watchdog
//   16-bit saturating cycle counter used as a global run watchdog.
//   Ports:
//     clk, rst : clock, async active-high reset
//     clr      : synchronous clear (start of a run)
//     en       : count this cycle
//     expire   : this enabled cycle brings the count to LIMIT (LIMIT >= 1)
// ---------------------------------------------------------------------------
module run_watchdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  // Firing on the increment that reaches LIMIT lets the controller leave RUN
  // on the same edge instead of one cycle late.
  assign expire = en && (count_q >= LAST);

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/run_checker.sv
// ---------------------------------------------------------------------------
// run_checker
//   Run controller and result checker for the singlecycle core. Resets the
//   core with a chosen start PC, waits for each program's end PC, compares
//   the writeback value against the expected one and reports pass/fail,
//   all under one global watchdog.
//   Ports:
//     CLK, reset         : core clock, async active-high reset
//     start              : one-cycle pulse, honoured only in IDLE/DONE
//     start_pc           : PC presented to the core during its reset
//     end_pc, expect_val : packed per-program end PC / expected value
//     currentpc          : core current PC
//     MemtoRegOut        : core writeback value
//     cpu_resetl         : active-low core reset
//     cpu_startpc        : start PC to the core
//     busy, done         : run in progress / run finished (held)
//     pass_mask          : bit i set = program i passed
//     pass_count         : number of programs passed
//     all_passed         : done and every program passed
//     wdog_expired       : run aborted by the watchdog
//     fail_value         : MemtoRegOut at the first failing check
// ---------------------------------------------------------------------------
module run_checker
  import run_checker_pkg::*;
#(
  parameter int unsigned NUM_PROGS  = 2,
  parameter int unsigned WDOG_LIMIT = 255,
  parameter int unsigned RST_CYCLES = 1
) (
  input  logic                        CLK,
  input  logic                        reset,
  input  logic                        start,
  input  logic [PC_W-1:0]             start_pc,
  input  logic [PC_W*NUM_PROGS-1:0]   end_pc,
  input  logic [DATA_W*NUM_PROGS-1:0] expect_val,
  input  logic [PC_W-1:0]             currentpc,
  input  logic [DATA_W-1:0]           MemtoRegOut,
  output logic                        cpu_resetl,
  output logic [PC_W-1:0]             cpu_startpc,
  output logic                        busy,
  output logic                        done,
  output logic [NUM_PROGS-1:0]        pass_mask,
  output logic [7:0]                  pass_count,
  output logic                        all_passed,
  output logic                        wdog_expired,
  output logic [DATA_W-1:0]           fail_value
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PROGS - 1);

  state_e                state_q,        state_d;
  logic [IDX_W-1:0]      idx_q,          idx_d;
  logic [3:0]            rst_cnt_q,      rst_cnt_d;
  logic                  cpu_resetl_q,   cpu_resetl_d;
  logic [PC_W-1:0]       cpu_startpc_q,  cpu_startpc_d;
  logic                  busy_q,         busy_d;
  logic                  done_q,         done_d;
  logic [NUM_PROGS-1:0]  pass_mask_q,    pass_mask_d;
  logic [7:0]            pass_count_q,   pass_count_d;
  logic                  wdog_expired_q, wdog_expired_d;
  logic [DATA_W-1:0]     fail_value_q,   fail_value_d;
  // fail_value alone cannot mark "captured": a failing value may be zero.
  logic                  fail_seen_q,    fail_seen_d;

  logic              wd_clr;
  logic              wd_en;
  logic              wd_expire;
  logic [PC_W-1:0]   cur_end;
  logic [DATA_W-1:0] cur_exp;
  logic              reached;
  logic              matched;

  assign cur_end = get_slot(VEC_W'(end_pc), idx_q);
  assign cur_exp = get_slot(VEC_W'(expect_val), idx_q);
  assign reached = (currentpc >= cur_end);
  assign matched = (MemtoRegOut == cur_exp);

  run_watchdog #(
    .LIMIT(WDOG_LIMIT)
  ) u_wdog (
    .clk   (CLK),
    .rst   (reset),
    .clr   (wd_clr),
    .en    (wd_en),
    .expire(wd_expire)
  );

  // NOTE: every signal written here gets its default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    rst_cnt_d      = rst_cnt_q;
    cpu_resetl_d   = cpu_resetl_q;
    cpu_startpc_d  = cpu_startpc_q;
    busy_d         = busy_q;
    done_d         = done_q;
    pass_mask_d    = pass_mask_q;
    pass_count_d   = pass_count_q;
    wdog_expired_d = wdog_expired_q;
    fail_value_d   = fail_value_q;
    fail_seen_d    = fail_seen_q;
    wd_clr         = 1'b0;
    wd_en          = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          pass_mask_d    = '0;
          pass_count_d   = '0;
          wdog_expired_d = 1'b0;
          fail_value_d   = '0;
          fail_seen_d    = 1'b0;
          done_d         = 1'b0;
          idx_d          = '0;
          wd_clr         = 1'b1;
          cpu_startpc_d  = start_pc;
          cpu_resetl_d   = 1'b0;
          busy_d         = 1'b1;
          rst_cnt_d      = 4'(RST_CYCLES - 1);
          state_d        = ST_RST;
        end
      end

      ST_RST: begin
        if (rst_cnt_q == 4'd0) begin
          cpu_resetl_d = 1'b1;
          state_d      = ST_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q - 4'd1;
        end
      end

      ST_RUN: begin
        if (reached) begin
          // A reach always wins over the watchdog: wd_en stays low here.
          if (matched) begin
            pass_mask_d  = pass_mask_q | (NUM_PROGS'(1) << idx_q);
            pass_count_d = pass_count_q + 8'd1;
          end else if (!fail_seen_q) begin
            fail_value_d = MemtoRegOut;
            fail_seen_d  = 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            // Next slot is evaluated on the following edge at the earliest.
            idx_d = idx_q + 1'b1;
          end
        end else begin
          wd_en = 1'b1;
          if (wd_expire) begin
            wdog_expired_d = 1'b1;
            busy_d         = 1'b0;
            done_d         = 1'b1;
            state_d        = ST_DONE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      rst_cnt_q      <= '0;
      cpu_resetl_q   <= 1'b1;
      cpu_startpc_q  <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_mask_q    <= '0;
      pass_count_q   <= '0;
      wdog_expired_q <= 1'b0;
      fail_value_q   <= '0;
      fail_seen_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      rst_cnt_q      <= rst_cnt_d;
      cpu_resetl_q   <= cpu_resetl_d;
      cpu_startpc_q  <= cpu_startpc_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      pass_mask_q    <= pass_mask_d;
      pass_count_q   <= pass_count_d;
      wdog_expired_q <= wdog_expired_d;
      fail_value_q   <= fail_value_d;
      fail_seen_q    <= fail_seen_d;
    end
  end

  assign cpu_resetl   = cpu_resetl_q;
  assign cpu_startpc  = cpu_startpc_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass_mask    = pass_mask_q;
  assign pass_count   = pass_count_q;
  assign wdog_expired = wdog_expired_q;
  assign fail_value   = fail_value_q;
  assign all_passed   = done_q && (pass_count_q == 8'(NUM_PROGS));

endmodule

// File: tb/tb_run_checker.sv
// ---------------------------------------------------------------------------
// tb_run_checker
//   Bench for run_checker. A behavioural core model (PC := startpc while held
//   in reset, else PC += 4; optional PC stuck at 0x10) drives currentpc, and
//   MemtoRegOut is looked up from two bench-chosen (pc, value) pairs.
//   Instance dut: NUM_PROGS=2, WDOG_LIMIT=255, RST_CYCLES=1.
//   Instance dut3: NUM_PROGS=1, RST_CYCLES=3 (reset sequencing, ignored start).
// ---------------------------------------------------------------------------
module tb_run_checker;

  logic CLK;
  logic rst;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // ---------------- main instance ----------------
  logic         start;
  logic [63:0]  start_pc;
  logic [127:0] end_pc;
  logic [127:0] expect_val;
  logic [63:0]  currentpc;
  logic [63:0]  mem_out;
  logic         cpu_resetl;
  logic [63:0]  cpu_startpc;
  logic         busy, done, all_passed, wdog_expired;
  logic [1:0]   pass_mask;
  logic [7:0]   pass_count;
  logic [63:0]  fail_value;

  logic         stuck;
  logic [63:0]  drv_pc0, drv_val0, drv_pc1, drv_val1;

  run_checker #(
    .NUM_PROGS (2),
    .WDOG_LIMIT(255),
    .RST_CYCLES(1)
  ) dut (
    .CLK         (CLK),
    .reset       (rst),
    .start       (start),
    .start_pc    (start_pc),
    .end_pc      (end_pc),
    .expect_val  (expect_val),
    .currentpc   (currentpc),
    .MemtoRegOut (mem_out),
    .cpu_resetl  (cpu_resetl),
    .cpu_startpc (cpu_startpc),
    .busy        (busy),
    .done        (done),
    .pass_mask   (pass_mask),
    .pass_count  (pass_count),
    .all_passed  (all_passed),
    .wdog_expired(wdog_expired),
    .fail_value  (fail_value)
  );

  always_ff @(posedge CLK) begin
    if (stuck)            currentpc <= 64'h10;
    else if (!cpu_resetl) currentpc <= cpu_startpc;
    else                  currentpc <= currentpc + 64'd4;
  end

  always_comb begin
    mem_out = 64'hDEAD_BEEF_0000_0000;
    if (currentpc == drv_pc0)      mem_out = drv_val0;
    else if (currentpc == drv_pc1) mem_out = drv_val1;
  end

  // ---------------- RST_CYCLES=3 instance ----------------
  logic        b_start;
  logic [63:0] b_start_pc, b_pc, b_mem;
  logic        b_resetl, b_busy, b_done, b_all, b_wdog;
  logic [63:0] b_startpc_out, b_fail;
  logic [0:0]  b_mask;
  logic [7:0]  b_count;

  run_checker #(
    .NUM_PROGS (1),
    .WDOG_LIMIT(255),
    .RST_CYCLES(3)
  ) dut3 (
    .CLK         (CLK),
    .reset       (rst),
    .start       (b_start),
    .start_pc    (b_start_pc),
    .end_pc      (64'h120),
    .expect_val  (64'h77),
    .currentpc   (b_pc),
    .MemtoRegOut (b_mem),
    .cpu_resetl  (b_resetl),
    .cpu_startpc (b_startpc_out),
    .busy        (b_busy),
    .done        (b_done),
    .pass_mask   (b_mask),
    .pass_count  (b_count),
    .all_passed  (b_all),
    .wdog_expired(b_wdog),
    .fail_value  (b_fail)
  );

  always_ff @(posedge CLK) begin
    if (!b_resetl) b_pc <= b_startpc_out;
    else           b_pc <= b_pc + 64'd4;
  end
  assign b_mem = (b_pc == 64'h120) ? 64'h77 : 64'h0;

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [63:0] end0, end1, exp0, exp1;
    logic [63:0] pc0, val0, pc1, val1;
    logic        stuck;
    logic [1:0]  mask;
    logic [7:0]  count;
    logic        all;
    logic        wdog;
    logic [63:0] fail;
    int          cycles; // RUN edges from RST exit until done
  } vec_t;

  vec_t vecs[7];

  task automatic start_run(input vec_t v);
    end_pc     = {v.end1, v.end0};
    expect_val = {v.exp1, v.exp0};
    drv_pc0 = v.pc0; drv_val0 = v.val0;
    drv_pc1 = v.pc1; drv_val1 = v.val1;
    stuck    = v.stuck;
    start_pc = 64'h0;
    @(posedge CLK); #1 start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
  endtask

  task automatic run_vector(input vec_t v);
    int n;
    int k;
    start_run(v);
    check({v.name, ".busy_after_start"}, 64'(busy), 64'd1);
    k = 0;
    while (!cpu_resetl && k < 20) begin
      @(posedge CLK); #1;
      k++;
    end
    check({v.name, ".rst_exit"}, 64'(cpu_resetl), 64'd1);
    n = 0;
    while (!done && n < 400) begin
      @(posedge CLK); #1;
      n++;
    end
    check({v.name, ".cycles"}, 64'(n), 64'(v.cycles));
    check({v.name, ".done"}, 64'(done), 64'd1);
    check({v.name, ".busy"}, 64'(busy), 64'd0);
    check({v.name, ".pass_mask"}, 64'(pass_mask), 64'(v.mask));
    check({v.name, ".pass_count"}, 64'(pass_count), 64'(v.count));
    check({v.name, ".all_passed"}, 64'(all_passed), 64'(v.all));
    check({v.name, ".wdog_expired"}, 64'(wdog_expired), 64'(v.wdog));
    check({v.name, ".fail_value"}, fail_value, v.fail);
    @(posedge CLK); #1;
    check({v.name, ".done_held"}, 64'(done), 64'd1);
  endtask

  initial begin
    int k;
    int lowc;

    //        name        end0     end1     exp0     exp1                    pc0      val0     pc1      val1                    stk   mask   cnt  all   wd    fail    cyc
    vecs[0] = '{"nominal",  64'h30, 64'h54,  64'hF,   64'h123456789abcdef0,  64'h30,  64'hF,   64'h54,  64'h123456789abcdef0,  1'b0, 2'b11, 8'd2, 1'b1, 1'b0, 64'h0, 22};
    vecs[1] = '{"mismatch0",64'h30, 64'h54,  64'hF,   64'h123456789abcdef0,  64'h30,  64'hE,   64'h54,  64'h123456789abcdef0,  1'b0, 2'b10, 8'd1, 1'b0, 1'b0, 64'hE, 22};
    vecs[2] = '{"watchdog", 64'h30, 64'h54,  64'hF,   64'h1,                 64'h30,  64'hF,   64'h54,  64'h1,                 1'b1, 2'b00, 8'd0, 1'b0, 1'b1, 64'h0, 255};
    vecs[3] = '{"reach_lim",64'h30, 64'h3FC, 64'hF,   64'hAA,                64'h30,  64'hF,   64'h3FC, 64'hAA,                1'b0, 2'b11, 8'd2, 1'b1, 1'b0, 64'h0, 256};
    vecs[4] = '{"miss_lim", 64'h30, 64'h400, 64'hF,   64'hAA,                64'h30,  64'hF,   64'h400, 64'hAA,                1'b0, 2'b01, 8'd1, 1'b0, 1'b1, 64'h0, 256};
    vecs[5] = '{"same_end", 64'h30, 64'h30,  64'h5,   64'h6,                 64'h30,  64'h5,   64'h34,  64'h6,                 1'b0, 2'b11, 8'd2, 1'b1, 1'b0, 64'h0, 14};
    vecs[6] = '{"both_bad", 64'h30, 64'h54,  64'h1,   64'h2,                 64'h30,  64'h3,   64'h54,  64'h4,                 1'b0, 2'b00, 8'd0, 1'b0, 1'b0, 64'h3, 22};

    rst = 1'b1; start = 1'b0; start_pc = '0; end_pc = '0; expect_val = '0;
    stuck = 1'b0; drv_pc0 = '1; drv_val0 = '0; drv_pc1 = '1; drv_val1 = '0;
    b_start = 1'b0; b_start_pc = '0;
    #12;
    check("reset.cpu_resetl", 64'(cpu_resetl), 64'd1);
    check("reset.cpu_startpc", cpu_startpc, 64'd0);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.pass_mask", 64'(pass_mask), 64'd0);
    check("reset.pass_count", 64'(pass_count), 64'd0);
    check("reset.all_passed", 64'(all_passed), 64'd0);
    check("reset.wdog_expired", 64'(wdog_expired), 64'd0);
    check("reset.fail_value", fail_value, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vector(vecs[i]);

    // Async reset mid-run while checking program 1.
    start_run(vecs[0]);
    k = 0;
    while (pass_count != 8'd1 && k < 100) begin
      @(posedge CLK); #1;
      k++;
    end
    check("midrst.reached_idx1", 64'(pass_count), 64'd1);
    @(posedge CLK); #1;
    check("midrst.busy_before", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst.cpu_resetl", 64'(cpu_resetl), 64'd1);
    check("midrst.cpu_startpc", cpu_startpc, 64'd0);
    check("midrst.busy", 64'(busy), 64'd0);
    check("midrst.done", 64'(done), 64'd0);
    check("midrst.pass_mask", 64'(pass_mask), 64'd0);
    check("midrst.pass_count", 64'(pass_count), 64'd0);
    check("midrst.wdog_expired", 64'(wdog_expired), 64'd0);
    check("midrst.fail_value", fail_value, 64'd0);
    #2 rst = 1'b0;
    run_vector(vecs[0]);

    // RST_CYCLES=3 sequencing and start ignored while busy.
    b_start_pc = 64'h100;
    @(posedge CLK); #1 b_start = 1'b1;
    @(posedge CLK); #1 b_start = 1'b0;
    check("rst3.low_at_start", 64'(b_resetl), 64'd0);
    check("rst3.startpc", b_startpc_out, 64'h100);
    lowc = 1;
    for (int j = 0; j < 20 && !b_resetl; j++) begin
      @(posedge CLK); #1;
      check("rst3.startpc_held", b_startpc_out, 64'h100);
      if (!b_resetl) lowc++;
    end
    check("rst3.low_cycles", 64'(lowc), 64'd3);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    b_start_pc = 64'h200;
    b_start = 1'b1;
    @(posedge CLK); #1 b_start = 1'b0;
    check("ignore.cpu_resetl", 64'(b_resetl), 64'd1);
    check("ignore.cpu_startpc", b_startpc_out, 64'h100);
    check("ignore.busy", 64'(b_busy), 64'd1);
    check("ignore.done", 64'(b_done), 64'd0);
    k = 0;
    while (!b_done && k < 400) begin
      @(posedge CLK); #1;
      k++;
    end
    check("rst3.done", 64'(b_done), 64'd1);
    check("rst3.pass_mask", 64'(b_mask), 64'd1);
    check("rst3.pass_count", 64'(b_count), 64'd1);
    check("rst3.all_passed", 64'(b_all), 64'd1);
    check("rst3.wdog_expired", 64'(b_wdog), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
